shared_div_unit: RTL

- Iterative radix-2 MIPS DIV/DIVU engine shared by NUM_PORTS issue ports.
- Sits directly downstream of the mutex-lock arbiter.
- Consumes the per-port grant vector, latches the operands of the granted port and runs a DATA_WIDTH-cycle division.
- Holds the quotient (LO) and remainder (HI) until the owning port acknowledges, then drives that port's release_lock back into the arbiter.

---
 rtl/shared_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shared_div_unit.sv
// Shared iterative radix-2 DIV/DIVU engine behind the mutex-lock arbiter.
// Ports: per-port grant/start/is_signed/dividend/divisor/result_ack in,
// flush in; done/release_lock per port, quotient (LO), remainder (HI), busy.
module shared_div_unit #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  grant,
  input  logic [NUM_PORTS-1:0]                  start,
  input  logic [NUM_PORTS-1:0]                  is_signed,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  dividend,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  divisor,
  input  logic [NUM_PORTS-1:0]                  result_ack,
  input  logic                                  flush,
  output logic [NUM_PORTS-1:0]                  done,
  output logic [DATA_WIDTH-1:0]                 quotient,
  output logic [DATA_WIDTH-1:0]                 remainder,
  output logic [NUM_PORTS-1:0]                  release_lock,
  output logic                                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IW-1:0]  owner_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   dvs_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic           dz_q;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] rel;
  logic [IW-1:0]        acc_idx;
  logic                 accept;
  logic [W-1:0]         a_sel;
  logic [W-1:0]         b_sel;
  logic                 a_neg;
  logic                 b_neg;
  logic [W-1:0]         a_mag;
  logic [W-1:0]         b_mag;
  logic [W:0]           shifted;
  logic [W:0]           diff;
  logic                 ge;
  logic [W-1:0]         r_step;
  logic [W-1:0]         q_step;

  // Operand select and one restoring shift-subtract step.
  always_comb begin
    req     = grant & start;
    acc_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) acc_idx = IW'(i);
    end
    accept  = (state_q == IDLE) && !flush && (|req);
    a_sel   = dividend[acc_idx];
    b_sel   = divisor[acc_idx];
    a_neg   = is_signed[acc_idx] & a_sel[W-1];
    b_neg   = is_signed[acc_idx] & b_sel[W-1];
    a_mag   = a_neg ? -a_sel : a_sel;
    b_mag   = b_neg ? -b_sel : b_sel;
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[W];
    r_step  = ge ? diff[W-1:0] : shifted[W-1:0];
    q_step  = {quo_q[W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    rel     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (flush) begin
          state_d      = IDLE;
          rel[owner_q] = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || result_ack[owner_q]) begin
          state_d      = IDLE;
          rel[owner_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      done[i] = (state_q == DONE) && (owner_q == IW'(i));
    end
  end

  assign release_lock = rel;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= acc_idx;
        cnt_q   <= CW'(DATA_WIDTH);
        rem_q   <= '0;
        quo_q   <= a_mag;
        dvs_q   <= b_mag;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        dz_q    <= (b_sel == '0);
      end else if (state_q == BUSY && !flush) begin
        rem_q <= r_step;
        quo_q <= q_step;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Zero divisor: quotient all ones; remainder fixup restores dividend.
          quotient  <= dz_q ? '1 : (q_neg_q ? -q_step : q_step);
          remainder <= r_neg_q ? -r_step : r_step;
        end
      end
    end
  end

  // Two simultaneous grant+start in IDLE is an arbiter protocol error.
  a_one_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && !flush) |-> $onehot0(grant & start)
  );

endmodule
